// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// ---------------------------------------------------------------------------
// Sequences byte / word / long loads and stores from a single requester onto
// a 32-bit single-port RAM with one cycle of read latency. Addresses are
// converted to long addresses. Store data and lane masks are shifted to the
// byte offset. Load data is shifted down and zero-extended.
//
// Build option: RAM_ACCESS_BE_EN
//   undefined : sub-long stores use read-modify-write (IDLE-READ-WAIT-WRITE-DONE),
//               ram_be_o is 4'b1111 during WRITE and 0 otherwise.
//   defined   : every store goes IDLE-WRITE-DONE using per-lane byte enables.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   req_i        access request, only looked at while idle
//   we_i         1 = store, 0 = load
//   size_i       00 byte, 01 word, 10 long, 11 illegal
//   addr_i       byte address
//   wdata_i      store data, right-aligned
//   rdata_o      load result, zero-extended (valid with ack_o)
//   ack_o        one-cycle completion pulse
//   err_o        alignment / size error (valid with ack_o)
//   busy_o       high whenever the controller is not idle
//   ram_addr_o   long address to the RAM
//   ram_we_o     RAM write strobe
//   ram_be_o     RAM byte enables, bit k covers bits 8k+7:8k
//   ram_wdata_o  RAM write data
//   ram_rdata_i  RAM read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module ram_access_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [ADDR_W-3:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_be_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b01;
    localparam logic [1:0] SIZE_LONG = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic [1:0]          off_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                ack_q;
    logic                err_q;
    logic                busy_q;
    logic [ADDR_W-3:0]   ramAddr_q;
    logic                ramWe_q;
    logic [3:0]          ramBe_q;
    logic [31:0]         ramWdata_q;

    // Mask covering the bytes of an access, right-aligned.
    function automatic logic [31:0] sizeMask(input logic [1:0] s);
        case (s)
            SIZE_BYTE: return 32'h0000_00FF;
            SIZE_WORD: return 32'h0000_FFFF;
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Illegal size or an access that would straddle its natural boundary.
    function automatic logic accessError(input logic [1:0] s, input logic [1:0] off);
        case (s)
            SIZE_BYTE: return 1'b0;
            SIZE_WORD: return off[0];
            SIZE_LONG: return off != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

`ifdef RAM_ACCESS_BE_EN
    // Byte enables derived from the lane mask of the access.
    function automatic logic [3:0] laneBe(input logic [1:0] s, input logic [1:0] off);
        case (s)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_WORD: return 4'b0011 << off;
            default:   return 4'b1111;
        endcase
    endfunction
`endif

    logic [31:0] laneMask_d;
    logic [31:0] rmwData_d;
    logic [31:0] loadData_d;
    logic        directWrite_d;
    logic [3:0]  directBe_d;

    // The merge uses ram_rdata_i at the WAIT->WRITE edge, which is exactly the
    // word captured in WAIT, so no separate capture register is needed.
    assign laneMask_d = sizeMask(size_q) << {off_q, 3'b000};
    assign rmwData_d  = (ram_rdata_i & ~laneMask_d) | ((wdata_q << {off_q, 3'b000}) & laneMask_d);
    assign loadData_d = (ram_rdata_i >> {off_q, 3'b000}) & sizeMask(size_q);

    // Stores that can be issued without reading the RAM first.
`ifdef RAM_ACCESS_BE_EN
    assign directWrite_d = we_i;
    assign directBe_d    = laneBe(size_i, addr_i[1:0]);
`else
    assign directWrite_d = we_i && (size_i == SIZE_LONG);
    assign directBe_d    = 4'b1111;
`endif

    // Controller FSM. All outputs are registered and change on the edge that
    // enters the state they belong to; strobes default low every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            off_q      <= 2'b00;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ramAddr_q  <= '0;
            ramWe_q    <= 1'b0;
            ramBe_q    <= 4'b0000;
            ramWdata_q <= '0;
        end else begin
            ack_q   <= 1'b0;
            ramWe_q <= 1'b0;
            ramBe_q <= 4'b0000;

            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q      <= we_i;
                        size_q    <= size_i;
                        off_q     <= addr_i[1:0];
                        wdata_q   <= wdata_i;
                        ramAddr_q <= addr_i[ADDR_W-1:2];
                        busy_q    <= 1'b1;
                        if (accessError(size_i, addr_i[1:0])) begin
                            err_q   <= 1'b1;
                            ack_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (directWrite_d) begin
                            err_q      <= 1'b0;
                            ramWe_q    <= 1'b1;
                            ramBe_q    <= directBe_d;
                            ramWdata_q <= wdata_i << {addr_i[1:0], 3'b000};
                            state_q    <= WRITE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= READ;
                        end
                    end
                end

                READ: begin
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (we_q) begin
                        ramWe_q    <= 1'b1;
                        ramBe_q    <= 4'b1111;
                        ramWdata_q <= rmwData_d;
                        state_q    <= WRITE;
                    end else begin
                        rdata_q <= loadData_d;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end

                WRITE: begin
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign ram_addr_o  = ramAddr_q;
    assign ram_we_o    = ramWe_q;
    assign ram_be_o    = ramBe_q;
    assign ram_wdata_o = ramWdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// ---------------------------------------------------------------------------
// Directed testbench for ram_access_ctrl with a small behavioural RAM model
// (16 longs, one cycle read latency, byte-enabled writes). Honours the
// RAM_ACCESS_BE_EN build option for the store timing and write data.
// ---------------------------------------------------------------------------
module tb_ram_access_ctrl;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    logic              err;
    logic              busy;
    logic [ADDR_W-3:0] ramAddr;
    logic              ramWe;
    logic [3:0]        ramBe;
    logic [31:0]       ramWdata;
    logic [31:0]       ramRdata;

    // Preload port into the RAM model so only one process writes the array.
    logic              preWe;
    logic [3:0]        preAddr;
    logic [31:0]       preData;

    logic [31:0]       mem [16];
    int                wrCount = 0;
    logic [ADDR_W-3:0] lastWrAddr;
    logic [31:0]       lastWrData;
    logic [3:0]        lastWrBe;

    int errors = 0;
    int checks = 0;
    int cyc;
    int wrBase;

    ram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .size_i      (size),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .ack_o       (ack),
        .err_o       (err),
        .busy_o      (busy),
        .ram_addr_o  (ramAddr),
        .ram_we_o    (ramWe),
        .ram_be_o    (ramBe),
        .ram_wdata_o (ramWdata),
        .ram_rdata_i (ramRdata)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, lane-wise write, write log for checking.
    always @(posedge clk) begin
        if (preWe) begin
            mem[preAddr] <= preData;
        end else if (ramWe) begin
            for (int k = 0; k < 4; k++) begin
                if (ramBe[k]) mem[ramAddr[3:0]][8*k +: 8] <= ramWdata[8*k +: 8];
            end
            wrCount    <= wrCount + 1;
            lastWrAddr <= ramAddr;
            lastWrData <= ramWdata;
            lastWrBe   <= ramBe;
        end
        ramRdata <= mem[ramAddr[3:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        preWe   = 1'b1;
        preAddr = a;
        preData = d;
        tick();
        preWe   = 1'b0;
    endtask

    // One request: accept, wait (bounded) for ack, check timing and err,
    // then step into the following idle cycle.
    task automatic applyStimulus(input string tag, input logic w, input logic [1:0] s,
                                 input logic [ADDR_W-1:0] a, input logic [31:0] d,
                                 input int expCycles, input logic expErr);
        int n;
        req   = 1'b1;
        we    = w;
        size  = s;
        addr  = a;
        wdata = d;
        tick();
        req = 1'b0;
        n   = 1;
        while (ack !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_ackCycles"}, n, expCycles);
        checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, expErr});
        tick();
        checkOutput({tag, "_ackPulse"}, {31'd0, ack}, 32'd0);
        checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        size  = 2'b00;
        addr  = '0;
        wdata = '0;
        preWe = 1'b0;
        preAddr = '0;
        preData = '0;
        tick();
        tick();

        // Reset values
        checkOutput("rst_rdata",    rdata, 32'd0);
        checkOutput("rst_ack",      {31'd0, ack}, 32'd0);
        checkOutput("rst_err",      {31'd0, err}, 32'd0);
        checkOutput("rst_busy",     {31'd0, busy}, 32'd0);
        checkOutput("rst_ramWe",    {31'd0, ramWe}, 32'd0);
        checkOutput("rst_ramBe",    {28'd0, ramBe}, 32'd0);
        checkOutput("rst_ramAddr",  {18'd0, ramAddr}, 32'd0);
        checkOutput("rst_ramWdata", ramWdata, 32'd0);
        rst = 1'b0;
        tick();

        preload(4'd0, 32'hAABBCCDD);
        preload(4'd1, 32'h11223344);
        preload(4'd2, 32'h00000000);

        // Long load
        wrBase = wrCount;
        applyStimulus("longLoad", 1'b0, 2'b10, 16'h0004, 32'd0, 3, 1'b0);
        checkOutput("longLoad_rdata", rdata, 32'h11223344);
        checkOutput("longLoad_noWrite", wrCount - wrBase, 32'd0);

        // Byte and word loads with offset
        applyStimulus("byteLoad", 1'b0, 2'b00, 16'h0002, 32'd0, 3, 1'b0);
        checkOutput("byteLoad_rdata", rdata, 32'h000000BB);
        applyStimulus("wordLoad", 1'b0, 2'b01, 16'h0002, 32'd0, 3, 1'b0);
        checkOutput("wordLoad_rdata", rdata, 32'h0000AABB);

        // Byte store at offset 1
        wrBase = wrCount;
`ifdef RAM_ACCESS_BE_EN
        applyStimulus("byteStore", 1'b1, 2'b00, 16'h0001, 32'h00000055, 2, 1'b0);
        checkOutput("byteStore_wdata", lastWrData, 32'h00005500);
        checkOutput("byteStore_be", {28'd0, lastWrBe}, 32'h2);
`else
        applyStimulus("byteStore", 1'b1, 2'b00, 16'h0001, 32'h00000055, 4, 1'b0);
        checkOutput("byteStore_wdata", lastWrData, 32'hAABB55DD);
        checkOutput("byteStore_be", {28'd0, lastWrBe}, 32'hF);
`endif
        checkOutput("byteStore_writes", wrCount - wrBase, 32'd1);
        checkOutput("byteStore_addr", {18'd0, lastWrAddr}, 32'd0);
        applyStimulus("byteStoreRb", 1'b0, 2'b10, 16'h0000, 32'd0, 3, 1'b0);
        checkOutput("byteStoreRb_rdata", rdata, 32'hAABB55DD);

        // Error cases: ack one cycle after accept, no RAM write, rdata held
        wrBase = wrCount;
        applyStimulus("errWord", 1'b1, 2'b01, 16'h0003, 32'h12345678, 1, 1'b1);
        applyStimulus("errLong", 1'b0, 2'b10, 16'h0002, 32'd0, 1, 1'b1);
        applyStimulus("errSize", 1'b1, 2'b11, 16'h0000, 32'hFFFFFFFF, 1, 1'b1);
        checkOutput("err_noWrite", wrCount - wrBase, 32'd0);
        checkOutput("err_rdataHeld", rdata, 32'hAABB55DD);

        // Reset during WAIT
        wrBase = wrCount;
        req   = 1'b1;
`ifdef RAM_ACCESS_BE_EN
        we    = 1'b0;
`else
        we    = 1'b1;
`endif
        size  = 2'b01;
        addr  = 16'h0002;
        wdata = 32'h00001234;
        tick();
        req = 1'b0;
        checkOutput("midRst_busyBefore", {31'd0, busy}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midRst_ack", {31'd0, ack}, 32'd0);
        checkOutput("midRst_ramWe", {31'd0, ramWe}, 32'd0);
        checkOutput("midRst_rdata", rdata, 32'd0);
        tick();
        tick();
        checkOutput("midRst_noWrite", wrCount - wrBase, 32'd0);
        applyStimulus("midRstRb", 1'b0, 2'b10, 16'h0000, 32'd0, 3, 1'b0);
        checkOutput("midRstRb_rdata", rdata, 32'hAABB55DD);

        // Back-to-back with req held high: long store then load
        wrBase = wrCount;
        req   = 1'b1;
        we    = 1'b1;
        size  = 2'b10;
        addr  = 16'h0008;
        wdata = 32'hDEADBEEF;
        tick();
        cyc = 1;
        while (ack !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("b2bStore_ackCycles", cyc, 32'd2);
        we = 1'b0;
        tick();
        checkOutput("b2b_idleAck", {31'd0, ack}, 32'd0);
        checkOutput("b2b_idleBusy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("b2b_secondAccept", {31'd0, busy}, 32'd1);
        req = 1'b0;
        cyc = 0;
        while (ack !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("b2bLoad_ackCycles", cyc, 32'd2);
        checkOutput("b2bLoad_rdata", rdata, 32'hDEADBEEF);
        checkOutput("b2bLoad_err", {31'd0, err}, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("b2b_writes", wrCount - wrBase, 32'd1);
        checkOutput("b2b_wrData", lastWrData, 32'hDEADBEEF);
        checkOutput("b2b_wrAddr", {18'd0, lastWrAddr}, 32'd2);
        checkOutput("b2b_wrBe", {28'd0, lastWrBe}, 32'hF);
        checkOutput("b2b_finalIdle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
